jtopll_wrseq: RTL and testbench
===============================

Name: jtopll_wrseq

Overview:
- CPU-side bus initiator for the OPLL core: turns queued (register, value) write requests into the two-phase address/data write cycle on the chip's din/addr/cs_n/wr_n pins.
- Enforces the YM2413 inter-write recovery times in cen ticks, so sound drivers, testbenches and ROM players can issue writes at clk rate without violating chip timing.
- Sits between a command source (CPU shim, VGM player) and the OPLL instance.

Parameters:
- STROBE_LEN, 2, cen ticks cs_n/wr_n held low per phase; legal 1..255
- ADDR_WAIT, 12, cen ticks idle after address phase before data phase; legal 0..255
- DATA_WAIT, 84, cen ticks idle after data phase before next request; legal 0..255

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cen  in  1  clock enable, same cen as fed to the OPLL; all timing counts cen ticks
- req_valid  in  1  request present
- req_ready  out  1  request accepted on clk edge where valid&ready
- req_reg  in  8  OPLL register index
- req_data  in  8  value to write
- busy  out  1  high whenever not IDLE (or FIFO non-empty when FIFO built)
- cs_n  out  1  to OPLL cs_n
- wr_n  out  1  to OPLL wr_n
- addr  out  1  to OPLL addr (0 = address phase, 1 = data phase)
- dout  out  8  to OPLL din

Behaviour:
- Reset (async, rst_n=0): state IDLE, cs_n=1, wr_n=1, addr=0, dout=0, req_ready=0 while in reset, busy=0, counter=0. Asserting mid-write aborts immediately; strobes go high in the same cycle.
- States: IDLE -> ASTB -> AWAIT -> DSTB -> DWAIT -> IDLE. 8-bit tick counter, cleared on every state entry, incremented only on cen=1.
- IDLE: req_ready=1. Handshake is sampled on any clk edge regardless of cen. On accept, latch reg/data; next cycle enter ASTB.
- ASTB: cs_n=0, wr_n=0, addr=0, dout=latched reg. Leave after STROBE_LEN cen ticks.
- AWAIT: cs_n=wr_n=1, addr/dout held. Leave after ADDR_WAIT cen ticks. ADDR_WAIT=0 skips the state (ASTB -> DSTB directly).
- DSTB: cs_n=0, wr_n=0, addr=1, dout=latched data. Leave after STROBE_LEN cen ticks.
- DWAIT: strobes high, addr=1, dout held. Leave after DATA_WAIT cen ticks. DATA_WAIT=0 skips to IDLE.
- req_ready=0 in all non-IDLE states. The first acceptance can occur on the cycle IDLE is re-entered.
- cs_n and wr_n always change together. Both are registered outputs and glitch-free.
- addr/dout become stable in the same cycle the strobe falls and do not change until the next phase.
- cen held 0: FSM freezes in its current state with outputs held.

Optional Feature:
- JTOPLL_WRSEQ_FIFO_EN defined: 4-entry FIFO (16-bit entries) in front of the FSM.
  - req_ready = FIFO not full.
  - FSM pops when IDLE and FIFO non-empty; the pop-to-ASTB latency matches the no-FIFO accept path (one clk).
  - Simultaneous push and pop allowed when full (pop frees the slot in the same cycle).
  - FIFO cleared on reset. busy covers FIFO non-empty.
- Undefined: no storage; req_ready as described above.

Test Plan:
- Defaults, cen=1, write reg 0x10 data 0x55 -> cs_n low for cycles 1-2 with addr=0, dout=0x10; high for 12 cycles; low for 2 cycles with addr=1, dout=0x55; high for 84 cycles; req_ready returns at cycle 101.
- Same write with cen pulsing 1 in 4 -> every phase duration ×4; total 400 clk; outputs held on cen=0.
- ADDR_WAIT=0, DATA_WAIT=0, STROBE_LEN=1, two back-to-back requests (0x30/0x11, 0x20/0x1C) -> strobe pattern low,low,high(IDLE accept),low,low with the correct addr/dout sequence.
- Assert rst_n=0 during DSTB -> cs_n, wr_n = 1 and addr = 0 asynchronously; after release the next request starts cleanly from ASTB.
- FIFO build: push 5 requests on consecutive clocks -> 5th stalls (req_ready=0) until the first pop; all 5 written in order; busy drops only after the last DWAIT.
- Random valid toggling with no accept while busy -> no extra or missing strobes; the latched reg/data are unaffected by input changes mid-write.

Source files
------------

// File: rtl/jtopll_wrseq.sv
// jtopll_wrseq: turns (register, value) write requests into the two-phase
// address/data bus cycle of the OPLL. Recovery times are counted in cen ticks.
// Optional build macro JTOPLL_WRSEQ_FIFO_EN adds a 4-entry request FIFO in
// front of the sequencer; without it there is no request storage.
module jtopll_wrseq #(
    parameter int unsigned STROBE_LEN = 2,   // 1..255
    parameter int unsigned ADDR_WAIT  = 12,  // 0..255
    parameter int unsigned DATA_WAIT  = 84   // 0..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       cs_n,
    output logic       wr_n,
    output logic       addr,
    output logic [7:0] dout
);

    typedef enum logic [2:0] {IDLE, ASTB, AWAIT, DSTB, DWAIT} state_t;

    // Terminal counts; a zero-length wait never uses its value.
    localparam logic [7:0] SL_M1 = 8'(STROBE_LEN - 1);
    localparam logic [7:0] AW_M1 = 8'(ADDR_WAIT - 1);
    localparam logic [7:0] DW_M1 = 8'(DATA_WAIT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q;
    logic [7:0] lat_data_q;
    logic       run_q;      // low during reset and the cycle it releases
    logic       start;      // a write starts on this edge
    logic [7:0] src_reg, src_data;
    logic       strb_d;

`ifdef JTOPLL_WRSEQ_FIFO_EN
    logic [15:0] fifo_mem [4];
    logic [1:0]  wp_q, rp_q;
    logic [2:0]  fcnt_q;
    logic        push, pop;

    // Pop straight into ASTB; a pop frees a slot for a same-cycle push.
    assign pop       = (state_q == IDLE) && (fcnt_q != 3'd0);
    assign req_ready = run_q && ((fcnt_q != 3'd4) || pop);
    assign push      = req_valid && req_ready;
    assign start     = pop;
    assign src_reg   = fifo_mem[rp_q][15:8];
    assign src_data  = fifo_mem[rp_q][7:0];
    assign busy      = (state_q != IDLE) || (fcnt_q != 3'd0);

    // FIFO storage, no reset needed: validity lives in the pointers
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wp_q] <= {req_reg, req_data};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q   <= 2'd0;
            rp_q   <= 2'd0;
            fcnt_q <= 3'd0;
        end else begin
            if (push) wp_q <= wp_q + 2'd1;
            if (pop)  rp_q <= rp_q + 2'd1;
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 3'd1;
                2'b01:   fcnt_q <= fcnt_q - 3'd1;
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end
`else
    assign req_ready = run_q && (state_q == IDLE);
    assign start     = req_valid && req_ready;
    assign src_reg   = req_reg;
    assign src_data  = req_data;
    assign busy      = (state_q != IDLE);
`endif

    // Next state: each phase ends on the cen tick that completes its length
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = ASTB;
            ASTB:  if (cen && cnt_q == SL_M1) state_d = (ADDR_WAIT == 0) ? DSTB : AWAIT;
            AWAIT: if (cen && cnt_q == AW_M1) state_d = DSTB;
            DSTB:  if (cen && cnt_q == SL_M1) state_d = (DATA_WAIT == 0) ? IDLE : DWAIT;
            DWAIT: if (cen && cnt_q == DW_M1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign strb_d = (state_d == ASTB) || (state_d == DSTB);

    // State register and tick counter, counter cleared on every state entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)              cnt_q <= 8'd0;
            else if (cen && state_q != IDLE)     cnt_q <= cnt_q + 8'd1;
        end
    end

    // Bus pins registered from the next state so strobes are glitch-free and
    // addr/dout settle in the same cycle the strobe falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            cs_n       <= 1'b1;
            wr_n       <= 1'b1;
            addr       <= 1'b0;
            dout       <= 8'd0;
            lat_data_q <= 8'd0;
        end else begin
            run_q <= 1'b1;
            cs_n  <= ~strb_d;
            wr_n  <= ~strb_d;
            if (start) lat_data_q <= src_data;
            if (state_d == ASTB && state_q != ASTB) begin
                addr <= 1'b0;
                dout <= src_reg;
            end
            if (state_d == DSTB && state_q != DSTB) begin
                addr <= 1'b1;
                dout <= lat_data_q;
            end
        end
    end

endmodule

// File: tb/tb_jtopll_wrseq.sv
// Bench for jtopll_wrseq: three instances with different timing share one
// stimulus stream; each is compared every cycle against a segment-list model.
module tb_jtopll_wrseq;

    localparam int NDUT = 3;
    localparam int SL [NDUT] = '{2, 1, 3};
    localparam int AW [NDUT] = '{12, 0, 0};
    localparam int DW [NDUT] = '{84, 0, 5};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_reg = 8'd0;
    logic [7:0] req_data = 8'd0;

    logic       req_ready_w [NDUT];
    logic       busy_w [NDUT];
    logic       cs_n_w [NDUT];
    logic       wr_n_w [NDUT];
    logic       addr_w [NDUT];
    logic [7:0] dout_w [NDUT];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        jtopll_wrseq #(
            .STROBE_LEN(SL[g]),
            .ADDR_WAIT (AW[g]),
            .DATA_WAIT (DW[g])
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .cen      (cen),
            .req_valid(req_valid),
            .req_ready(req_ready_w[g]),
            .req_reg  (req_reg),
            .req_data (req_data),
            .busy     (busy_w[g]),
            .cs_n     (cs_n_w[g]),
            .wr_n     (wr_n_w[g]),
            .addr     (addr_w[g]),
            .dout     (dout_w[g])
        );
    end

    // ---------------- reference model: a write is a list of segments ----------
    int         m_idx [NDUT];
    int         m_rem [NDUT];
    int         m_nseg [NDUT];
    bit         m_act [NDUT];
    bit         m_run [NDUT];
    int         s_len [NDUT][4];
    bit         s_cs [NDUT][4];
    bit         s_addr [NDUT][4];
    logic [7:0] s_val [NDUT][4];
    bit         e_addr [NDUT];
    logic [7:0] e_dout [NDUT];
    logic [15:0] fq [NDUT][8];
    int         fn [NDUT];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_pop(input int d);
`ifdef JTOPLL_WRSEQ_FIFO_EN
        return !m_act[d] && fn[d] > 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_ready(input int d);
`ifdef JTOPLL_WRSEQ_FIFO_EN
        return m_run[d] && (fn[d] < 4 || m_pop(d));
`else
        return m_run[d] && !m_act[d];
`endif
    endfunction

    function automatic bit m_busy(input int d);
        return m_act[d] || fn[d] > 0;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < NDUT; d++) begin
            m_act[d] = 0; m_run[d] = 0; m_idx[d] = 0; m_rem[d] = 0; m_nseg[d] = 0;
            e_addr[d] = 0; e_dout[d] = 8'd0; fn[d] = 0;
        end
    endtask

    task automatic m_add(input int d, input int len, input bit cs, input bit a, input logic [7:0] v);
        int n;
        n = m_nseg[d];
        s_len[d][n] = len; s_cs[d][n] = cs; s_addr[d][n] = a; s_val[d][n] = v;
        m_nseg[d] = n + 1;
    endtask

    task automatic m_start(input int d, input logic [7:0] r, input logic [7:0] v);
        m_nseg[d] = 0;
        m_add(d, SL[d], 1'b0, 1'b0, r);
        if (AW[d] > 0) m_add(d, AW[d], 1'b1, 1'b0, r);
        m_add(d, SL[d], 1'b0, 1'b1, v);
        if (DW[d] > 0) m_add(d, DW[d], 1'b1, 1'b1, v);
        m_idx[d] = 0; m_rem[d] = s_len[d][0]; m_act[d] = 1;
    endtask

    // Advance every model by one clk edge using the inputs currently driven
    task automatic model_edge();
        for (int d = 0; d < NDUT; d++) begin
            bit acc, pop;
            acc = req_valid && m_ready(d);
            pop = m_pop(d);
            if (m_act[d]) begin
                if (cen) begin
                    m_rem[d]--;
                    if (m_rem[d] == 0) begin
                        m_idx[d]++;
                        if (m_idx[d] == m_nseg[d]) m_act[d] = 0;
                        else m_rem[d] = s_len[d][m_idx[d]];
                    end
                end
            end else begin
`ifdef JTOPLL_WRSEQ_FIFO_EN
                if (pop) begin
                    m_start(d, fq[d][0][15:8], fq[d][0][7:0]);
                    for (int i = 0; i < 7; i++) fq[d][i] = fq[d][i+1];
                    fn[d]--;
                end
`else
                if (acc) m_start(d, req_reg, req_data);
`endif
            end
`ifdef JTOPLL_WRSEQ_FIFO_EN
            if (acc) begin
                fq[d][fn[d]] = {req_reg, req_data};
                fn[d]++;
            end
`endif
            if (m_act[d]) begin
                e_addr[d] = s_addr[d][m_idx[d]];
                e_dout[d] = s_val[d][m_idx[d]];
            end
            m_run[d] = 1;
            if (pop && acc && fn[d] > 4) chk("fifo_overflow", fn[d], 4);
        end
    endtask

    task automatic chk_all();
        for (int d = 0; d < NDUT; d++) begin
            bit ecs;
            ecs = m_act[d] ? s_cs[d][m_idx[d]] : 1'b1;
            chk($sformatf("cs_n[%0d]", d), cs_n_w[d], ecs);
            chk($sformatf("wr_n[%0d]", d), wr_n_w[d], ecs);
            chk($sformatf("addr[%0d]", d), addr_w[d], e_addr[d]);
            chk($sformatf("dout[%0d]", d), dout_w[d], e_dout[d]);
            chk($sformatf("busy[%0d]", d), busy_w[d], m_busy(d));
            chk($sformatf("ready[%0d]", d), req_ready_w[d], m_ready(d));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_all();
    endtask

    task automatic drain();
        int n;
        bit any;
        n = 0;
        req_valid = 1'b0;
        cen = 1'b1;
        any = 1;
        while (any && n < 2000) begin
            any = 0;
            for (int d = 0; d < NDUT; d++) if (m_busy(d)) any = 1;
            if (any) begin step(); n++; end
        end
        if (any) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        int lowc, rdy_at, busyc, hits;
        bit found;
        logic       p_cs [5];
        logic       p_addr [5];
        logic [7:0] p_dout [5];
        logic       x_cs [5];
        logic       x_addr [5];
        logic [7:0] x_dout [5];

        // reset state
        m_reset();
        @(negedge clk);
        chk("rst_cs_n", cs_n_w[0], 1);
        chk("rst_ready", req_ready_w[0], 0);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_dout", dout_w[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_all();
        step();

        // default timing, cen every cycle
        req_valid = 1'b1; req_reg = 8'h10; req_data = 8'h55; cen = 1'b1;
        step();
        req_valid = 1'b0;
        lowc = 0; rdy_at = -1;
        for (int c = 1; c < 1000 && rdy_at < 0; c++) begin
            if (!cs_n_w[0]) lowc++;
            if (req_ready_w[0]) rdy_at = c;
            else step();
        end
        chk("t1_ready_cycle", rdy_at, 101);
        chk("t1_low_cycles", lowc, 4);
        drain();

        // cen one clk in four: every phase stretched four times
        req_valid = 1'b1; req_reg = 8'h10; req_data = 8'h55; cen = 1'b1;
        step();
        req_valid = 1'b0;
        busyc = 0;
        for (int c = 1; c < 2000; c++) begin
            if (!busy_w[0]) break;
            busyc++;
            cen = (c % 4 == 0);
            step();
        end
        chk("t2_busy_cycles", busyc, 400);
        drain();

        // zero waits, single-tick strobes, back-to-back on instance 1
        x_cs   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        x_addr = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        x_dout = '{8'h30, 8'h11, 8'h11, 8'h20, 8'h1C};
        cen = 1'b1;
        req_valid = 1'b1; req_reg = 8'h30; req_data = 8'h11;
        step();
        req_reg = 8'h20; req_data = 8'h1C;
        for (int i = 0; i < 5; i++) begin
            p_cs[i] = cs_n_w[1]; p_addr[i] = addr_w[1]; p_dout[i] = dout_w[1];
            if (i == 3) req_valid = 1'b0;
            if (i < 4) step();
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_cs_%0d", i), p_cs[i], x_cs[i]);
            chk($sformatf("t3_addr_%0d", i), p_addr[i], x_addr[i]);
            chk($sformatf("t3_dout_%0d", i), p_dout[i], x_dout[i]);
        end
        drain();

        // async reset during the data strobe of instance 0
        req_valid = 1'b1; req_reg = 8'h2A; req_data = 8'hC3;
        step();
        req_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (m_act[0] && !s_cs[0][m_idx[0]] && s_addr[0][m_idx[0]]) found = 1;
            else step();
        end
        chk("t4_in_dstb", found, 1);
        chk("t4_cs_before", cs_n_w[0], 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_cs_async", cs_n_w[0], 1);
        chk("t4_wr_async", wr_n_w[0], 1);
        chk("t4_addr_async", addr_w[0], 0);
        chk("t4_dout_async", dout_w[0], 0);
        do_reset();
        step();
        req_valid = 1'b1; req_reg = 8'h0E; req_data = 8'h20;
        step();
        req_valid = 1'b0;
        chk("t4_restart_dout", dout_w[0], 8'h0E);
        chk("t4_restart_cs", cs_n_w[0], 0);
        drain();

`ifdef JTOPLL_WRSEQ_FIFO_EN
        // burst of consecutive pushes into the FIFO
        cen = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_reg = 8'(8'h40 + i); req_data = 8'(8'hA0 + i);
            step();
        end
        req_valid = 1'b0;
        drain();
`endif

        // random valid/cen with data changing under an active write
        hits = 0;
        for (int c = 0; c < 2500; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_reg   = 8'($urandom);
            req_data  = 8'($urandom);
            cen       = ($urandom_range(0, 3) != 0);
            if (req_valid && req_ready_w[1]) hits++;
            step();
        end
        chk("t5_some_accepts", (hits > 20) ? 1 : 0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
